mastermind_core: RTL and testbench
==================================

# mastermind_core

Parametrised game engine for the code-breaking game: it holds the secret code, accepts guesses over a valid/ready handshake, scores each guess sequentially into exact and partial match counts, and tracks turns, win and game-over. It keeps a readable per-turn history. It sits between the guess-entry/PRNG logic and the LED/seven-segment display drivers. It generalises the fixed 4-peg, 3-bit-colour, 8-turn top level to arbitrary peg count, colour width and turn limit.

## Interface
Parameters:
- PEGS, 4, pegs per code/guess (≥1)
- COLOR_W, 3, bits per peg colour; NC = 2^COLOR_W colours
- TURNS, 8, guesses allowed per game (≥1)
- Derived widths: CW = $clog2(PEGS+1); TW = $clog2(TURNS+1); HW = max(1,$clog2(TURNS))

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- new_game  in  1  pulse: latch code_in and start a game
- code_in  in  PEGS*COLOR_W  secret code; peg i = bits [i*COLOR_W +: COLOR_W]
- guess_valid  in  1  guess_in is offered
- guess_ready  out  1  core accepts a guess this cycle
- guess_in  in  PEGS*COLOR_W  guess, same packing as code_in
- result_valid  out  1  one-cycle pulse: score of the latest guess is on exact/partial
- exact  out  CW  pegs with correct colour and position (held until next result)
- partial  out  CW  correct colour, wrong position (held)
- turn  out  TW  guesses scored this game
- game_over  out  1  game ended (win or turns exhausted)
- win  out  1  game ended by a full-exact guess
- hist_sel  in  HW  history entry to read
- hist_guess  out  PEGS*COLOR_W  stored guess of entry hist_sel
- hist_exact  out  CW  stored exact count of entry hist_sel
- hist_partial  out  CW  stored partial count of entry hist_sel

## Operation
- FSM states: IDLE, PLAY, EXACT, COLOR, DONE, OVER.
- Reset (rst_n=0 at an edge): state IDLE; all outputs 0; history cleared.
- Any state + new_game=1: latch code_in, turn=0, game_over=0, win=0, exact=partial=0, clear history, go to PLAY. This aborts any in-flight scoring; no result_valid is emitted for an aborted guess. new_game has priority over guess_valid in the same cycle.
- PLAY: guess_ready=1. On guess_valid&&guess_ready, latch guess_in and go to EXACT. guess_ready=0 in every other state, and guess_valid is then ignored.
- EXACT (1 cycle): exact_acc = number of pegs i with code[i]==guess[i]. Clear match_acc and the colour index. Go to COLOR.
- COLOR (NC cycles, colour index c=0..NC-1): match_acc += min(count of c in code, count of c in guess). Counts are CW wide. After c=NC-1, go to DONE.
- DONE (1 cycle): exact=exact_acc; partial=match_acc−exact_acc (never negative); result_valid=1; write the guess and counts to history[turn]; turn+=1. If exact==PEGS, win=1 and game_over=1 and go to OVER. Else if the new turn==TURNS, game_over=1 and go to OVER. Otherwise go to PLAY.
- OVER: outputs hold; only new_game or reset leaves this state.
- History reads are combinational from hist_sel. If hist_sel ≥ turn, all hist_* outputs read 0.

## Timing
- Guess accepted at edge E0. EXACT occupies E0→E1. COLOR occupies E1→E1+NC. result_valid is high in the cycle after edge E1+NC+1. Latency is 2+NC cycles (10 for the defaults).
- exact, partial, turn, win, game_over and the history entry all update on the same edge that raises result_valid.
- guess_ready returns high the cycle after result_valid, unless the game is over. Minimum guess-to-guess spacing is NC+3 cycles.
- new_game takes effect on the edge where it is sampled; guess_ready is high in the next cycle.

## Configuration
- MASTERMIND_HISTORY_EN defined: the TURNS-entry history buffer and hist_* reads work as described.
- Not defined: no history storage is built; hist_guess, hist_exact and hist_partial are tied to 0. All other behaviour and timing are unchanged.

## Test plan
Defaults: PEGS=4, COLOR_W=3, TURNS=8. Pegs are listed peg0..peg3.
- Reset, then new_game with code {1,2,3,4}; guess {1,2,3,4} → 10 cycles later result_valid; exact=4, partial=0, win=1, game_over=1, turn=1, guess_ready=0.
- Code {1,1,2,2}, guess {2,2,1,1} → exact=0, partial=4. Code {1,2,3,4}, guess {1,1,1,1} → exact=1, partial=0.
- Code {0,0,0,0}, eight guesses {7,7,7,7} → each scores exact=0, partial=0. After the 8th: game_over=1, win=0, turn=8; further guess_valid is ignored.
- Assert new_game 4 cycles into scoring → no result_valid, turn=0, guess_ready=1 next cycle. Assert rst_n=0 mid-game → all outputs 0 on the next edge.
- With MASTERMIND_HISTORY_EN: after 3 guesses, hist_sel=0..2 return the stored guesses and counts, and hist_sel=3 returns zeros. Without the macro, hist_* are always 0.
- Hold guess_valid high continuously → exactly one acceptance per PLAY entry, spaced NC+3 cycles apart.

Source files
------------

// File: rtl/mastermind_core.sv
// mastermind_core: holds the secret code, scores guesses sequentially (exact pass, then one pass per colour)
// and tracks turns, win and game-over. Define MASTERMIND_HISTORY_EN to build the per-turn history buffer.
module mastermind_core #(
    parameter int PEGS    = 4,
    parameter int COLOR_W = 3,
    parameter int TURNS   = 8,
    localparam int CW = $clog2(PEGS + 1),
    localparam int TW = $clog2(TURNS + 1),
    localparam int HW = (TURNS > 1) ? $clog2(TURNS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      new_game,
    input  logic [PEGS*COLOR_W-1:0]   code_in,
    input  logic                      guess_valid,
    output logic                      guess_ready,
    input  logic [PEGS*COLOR_W-1:0]   guess_in,
    output logic                      result_valid,
    output logic [CW-1:0]             exact,
    output logic [CW-1:0]             partial,
    output logic [TW-1:0]             turn,
    output logic                      game_over,
    output logic                      win,
    input  logic [HW-1:0]             hist_sel,
    output logic [PEGS*COLOR_W-1:0]   hist_guess,
    output logic [CW-1:0]             hist_exact,
    output logic [CW-1:0]             hist_partial
);

    localparam int GW = PEGS * COLOR_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PLAY  = 3'd1;
    localparam logic [2:0] EXACT = 3'd2;
    localparam logic [2:0] COLOR = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] OVER  = 3'd5;

    logic [2:0]         state;
    logic [GW-1:0]      code_q;
    logic [GW-1:0]      guess_q;
    logic [CW-1:0]      exact_acc;
    logic [CW-1:0]      match_acc;
    logic [COLOR_W-1:0] color_idx;

    logic [CW-1:0] exact_cnt;
    logic [CW-1:0] code_cnt;
    logic [CW-1:0] guess_cnt;
    logic [CW-1:0] min_cnt;
    logic [CW-1:0] partial_cnt;
    logic [TW-1:0] turn_next;

    assign guess_ready = (state == PLAY);

    always_comb begin
        exact_cnt = '0;
        code_cnt  = '0;
        guess_cnt = '0;
        for (int i = 0; i < PEGS; i++) begin
            if (code_q[i*COLOR_W +: COLOR_W] == guess_q[i*COLOR_W +: COLOR_W])
                exact_cnt = exact_cnt + CW'(1);
            if (code_q[i*COLOR_W +: COLOR_W] == color_idx)
                code_cnt = code_cnt + CW'(1);
            if (guess_q[i*COLOR_W +: COLOR_W] == color_idx)
                guess_cnt = guess_cnt + CW'(1);
        end
        min_cnt     = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
        partial_cnt = (match_acc >= exact_acc) ? (match_acc - exact_acc) : '0;
        turn_next   = turn + TW'(1);
    end

    // new_game outranks everything, including an in-flight score, which is simply dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            code_q       <= '0;
            guess_q      <= '0;
            exact_acc    <= '0;
            match_acc    <= '0;
            color_idx    <= '0;
            result_valid <= 1'b0;
            exact        <= '0;
            partial      <= '0;
            turn         <= '0;
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (new_game) begin
                state     <= PLAY;
                code_q    <= code_in;
                exact     <= '0;
                partial   <= '0;
                turn      <= '0;
                game_over <= 1'b0;
                win       <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (guess_valid) begin
                            guess_q <= guess_in;
                            state   <= EXACT;
                        end
                    end
                    EXACT: begin
                        exact_acc <= exact_cnt;
                        match_acc <= '0;
                        color_idx <= '0;
                        state     <= COLOR;
                    end
                    COLOR: begin
                        match_acc <= match_acc + min_cnt;
                        color_idx <= color_idx + COLOR_W'(1);
                        if (color_idx == {COLOR_W{1'b1}})
                            state <= DONE;
                    end
                    DONE: begin
                        exact        <= exact_acc;
                        partial      <= partial_cnt;
                        result_valid <= 1'b1;
                        turn         <= turn_next;
                        if (exact_acc == CW'(PEGS)) begin
                            win       <= 1'b1;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (turn_next == TW'(TURNS)) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            state <= PLAY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MASTERMIND_HISTORY_EN
    logic [GW-1:0] hist_guess_mem   [TURNS];
    logic [CW-1:0] hist_exact_mem   [TURNS];
    logic [CW-1:0] hist_partial_mem [TURNS];
    logic          hist_sel_ok;

    // One entry per scored turn, written on the same edge that publishes the result
    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            for (int t = 0; t < TURNS; t++) begin
                hist_guess_mem[t]   <= '0;
                hist_exact_mem[t]   <= '0;
                hist_partial_mem[t] <= '0;
            end
        end else if (state == DONE) begin
            hist_guess_mem[turn[HW-1:0]]   <= guess_q;
            hist_exact_mem[turn[HW-1:0]]   <= exact_acc;
            hist_partial_mem[turn[HW-1:0]] <= partial_cnt;
        end
    end

    always_comb begin
        hist_sel_ok  = (TW'(hist_sel) < turn);
        hist_guess   = '0;
        hist_exact   = '0;
        hist_partial = '0;
        if (hist_sel_ok) begin
            hist_guess   = hist_guess_mem[hist_sel];
            hist_exact   = hist_exact_mem[hist_sel];
            hist_partial = hist_partial_mem[hist_sel];
        end
    end
`else
    logic unused_hist_sel;

    assign unused_hist_sel = ^hist_sel;
    assign hist_guess      = '0;
    assign hist_exact      = '0;
    assign hist_partial    = '0;
`endif

endmodule

// File: tb/tb_mastermind_core.sv
// Directed bench for mastermind_core at default parameters (4 pegs, 3-bit colours, 8 turns).
// Expected scores are hand-computed; history checks follow MASTERMIND_HISTORY_EN.
module tb_mastermind_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_game;
    logic [11:0] code_in;
    logic        guess_valid;
    logic        guess_ready;
    logic [11:0] guess_in;
    logic        result_valid;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic [3:0]  turn;
    logic        game_over;
    logic        win;
    logic [2:0]  hist_sel;
    logic [11:0] hist_guess;
    logic [2:0]  hist_exact;
    logic [2:0]  hist_partial;

    int n_vec  = 0;
    int n_fail = 0;

    mastermind_core #(.PEGS(4), .COLOR_W(3), .TURNS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_game     (new_game),
        .code_in      (code_in),
        .guess_valid  (guess_valid),
        .guess_ready  (guess_ready),
        .guess_in     (guess_in),
        .result_valid (result_valid),
        .exact        (exact),
        .partial      (partial),
        .turn         (turn),
        .game_over    (game_over),
        .win          (win),
        .hist_sel     (hist_sel),
        .hist_guess   (hist_guess),
        .hist_exact   (hist_exact),
        .hist_partial (hist_partial)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        logic [2:0] p0, p1, p2, p3;
        p0 = a[2:0];
        p1 = b[2:0];
        p2 = c[2:0];
        p3 = d[2:0];
        return {p3, p2, p1, p0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    task automatic start_game(input logic [11:0] code);
        new_game = 1'b1;
        code_in  = code;
        tick();
        new_game = 1'b0;
    endtask

    // Offer one guess, wait (bounded) for its result, and check latency and score
    task automatic apply_stimulus(input string tag, input logic [11:0] g, input int exp_e, input int exp_p);
        int n;
        guess_valid = 1'b1;
        guess_in    = g;
        tick();
        guess_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        check_output({tag, "_latency"}, n, 10);
        check_output({tag, "_exact"}, exact, exp_e);
        check_output({tag, "_partial"}, partial, exp_p);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, "_exact"}, exact, 0);
        check_output({tag, "_partial"}, partial, 0);
        check_output({tag, "_turn"}, turn, 0);
        check_output({tag, "_over"}, game_over, 0);
        check_output({tag, "_win"}, win, 0);
        check_output({tag, "_rv"}, result_valid, 0);
        check_output({tag, "_ready"}, guess_ready, 0);
    endtask

    task automatic check_hist(input int sel, input logic [11:0] g, input int e, input int p);
        hist_sel = sel[2:0];
        #1;
`ifdef MASTERMIND_HISTORY_EN
        check_output("hist_guess", hist_guess, g);
        check_output("hist_exact", hist_exact, e);
        check_output("hist_partial", hist_partial, p);
`else
        check_output("hist_guess_off", hist_guess, 0);
        check_output("hist_exact_off", hist_exact, 0);
        check_output("hist_partial_off", hist_partial, 0);
        if (e + p > 99) $display("[TB] unused %0d", g);
`endif
    endtask

    initial begin
        int accepts [$];
        bit saw_rv;

        rst_n = 1'b0; new_game = 1'b0; code_in = '0;
        guess_valid = 1'b0; guess_in = '0; hist_sel = '0;
        tick();
        tick();
        check_zero_outputs("reset");
        check_output("reset_hist", hist_guess, 0);
        rst_n = 1'b1;

        // Winning first guess
        start_game(pk(1, 2, 3, 4));
        check_output("ng_ready", guess_ready, 1);
        apply_stimulus("win", pk(1, 2, 3, 4), 4, 0);
        check_output("win_win", win, 1);
        check_output("win_over", game_over, 1);
        check_output("win_turn", turn, 1);
        check_output("win_ready", guess_ready, 0);

        // All colours right, all positions wrong
        start_game(pk(1, 1, 2, 2));
        check_output("ng2_turn", turn, 0);
        check_output("ng2_win", win, 0);
        apply_stimulus("swap", pk(2, 2, 1, 1), 0, 4);
        check_output("swap_ready", guess_ready, 1);
        check_output("swap_over", game_over, 0);
        tick();
        check_output("swap_rv_pulse", result_valid, 0);

        // Repeated colour counted once
        start_game(pk(1, 2, 3, 4));
        apply_stimulus("ones", pk(1, 1, 1, 1), 1, 0);

        // Exhaust all eight turns
        start_game(pk(0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            apply_stimulus("miss", pk(7, 7, 7, 7), 0, 0);
            check_output("miss_turn", turn, i + 1);
        end
        check_output("lose_over", game_over, 1);
        check_output("lose_win", win, 0);
        check_output("lose_ready", guess_ready, 0);
        guess_valid = 1'b1;
        saw_rv = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (result_valid) saw_rv = 1'b1;
        end
        guess_valid = 1'b0;
        check_output("lose_ignored_rv", saw_rv, 0);
        check_output("lose_ignored_turn", turn, 8);

        // Abort in the middle of scoring
        start_game(pk(1, 2, 3, 4));
        guess_valid = 1'b1;
        guess_in    = pk(1, 2, 3, 4);
        tick();
        guess_valid = 1'b0;
        saw_rv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (result_valid) saw_rv = 1'b1;
        end
        start_game(pk(5, 5, 5, 5));
        check_output("abort_turn", turn, 0);
        check_output("abort_ready", guess_ready, 1);
        for (int i = 0; i < 12; i++) begin
            if (result_valid) saw_rv = 1'b1;
            tick();
        end
        check_output("abort_no_rv", saw_rv, 0);
        check_output("abort_win", win, 0);

        // Continuous guess_valid: one acceptance per PLAY entry
        start_game(pk(0, 0, 0, 0));
        guess_valid = 1'b1;
        guess_in    = pk(7, 7, 7, 7);
        for (int c = 0; c < 30; c++) begin
            if (guess_valid && guess_ready) accepts.push_back(c);
            tick();
        end
        guess_valid = 1'b0;
        check_output("stream_count", accepts.size(), 3);
        if (accepts.size() == 3) begin
            check_output("stream_first", accepts[0], 0);
            check_output("stream_gap1", accepts[1] - accepts[0], 11);
            check_output("stream_gap2", accepts[2] - accepts[1], 11);
        end

        // History of three scored turns
        start_game(pk(1, 2, 3, 4));
        apply_stimulus("h0", pk(1, 1, 1, 1), 1, 0);
        apply_stimulus("h1", pk(4, 3, 2, 1), 0, 4);
        apply_stimulus("h2", pk(1, 2, 4, 3), 2, 2);
        check_output("h_turn", turn, 3);
        check_hist(0, pk(1, 1, 1, 1), 1, 0);
        check_hist(1, pk(4, 3, 2, 1), 0, 4);
        check_hist(2, pk(1, 2, 4, 3), 2, 2);
        hist_sel = 3'd3;
        #1;
        check_output("h3_guess", hist_guess, 0);
        check_output("h3_exact", hist_exact, 0);
        check_output("h3_partial", hist_partial, 0);

        // Reset in the middle of a game
        guess_valid = 1'b1;
        guess_in    = pk(4, 4, 4, 4);
        tick();
        guess_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midreset");
        hist_sel = 3'd0;
        #1;
        check_output("midreset_hist", hist_guess, 0);
        rst_n = 1'b1;
        tick();
        check_output("idle_ready", guess_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
